// File: rtl/trace_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// trace_uart_tx_pkg
// Types and constants shared by the trace UART readout:
//   SYNC_BYTE / FRAME_BYTES - frame layout constants
//   state_e                 - FSM state encoding (sequencer and byte transmitter)
//   sample_t                - 48-bit FIFO word {I[31:16], R[31:16], P[31:16]}
//   frame_checksum()        - XOR of the six data bytes of a sample
//   frame_byte()            - byte at a given index of the 8-byte frame
// -----------------------------------------------------------------------------
package trace_uart_tx_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    typedef logic [47:0] sample_t;

    function automatic logic [7:0] frame_checksum(input sample_t w);
        return w[47:40] ^ w[39:32] ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    // Frame order: sync, I hi, I lo, R hi, R lo, P hi, P lo, checksum.
    function automatic logic [7:0] frame_byte(input sample_t w,
                                              input logic [7:0] chk,
                                              input logic [2:0] idx);
        case (idx)
            3'd0:    return SYNC_BYTE;
            3'd1:    return w[47:40];
            3'd2:    return w[39:32];
            3'd3:    return w[31:24];
            3'd4:    return w[23:16];
            3'd5:    return w[15:8];
            3'd6:    return w[7:0];
            default: return chk;
        endcase
    endfunction

endpackage

// File: rtl/trace_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Sends one 8N1 byte (start 0, 8 data bits LSB first, stop 1) on txd_o.
//   clk      - system clock
//   rst      - asynchronous active-high reset; forces txd_o high
//   start_i  - request to send data_i; accepted while ready_o is high
//   data_i   - byte to send
//   ready_o  - high when idle, and in the last cycle of a stop bit so the next
//              byte can follow with no idle time on the line
//   txd_o    - serial output, registered, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx
    import trace_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);

    localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(CLKS_PER_BIT - 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   tick_q,  tick_d;
    logic [2:0]      bit_q,   bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q,   txd_d;
    logic            tick_last;

    assign tick_last = (tick_q == TICK_LAST);
    assign ready_o   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick_last);
    assign txd_o     = txd_q;

    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        tick_d  = tick_last ? '0 : tick_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (start_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick_last) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick_last) begin
                    // A waiting byte starts on the edge that ends this stop bit.
                    if (start_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/trace_uart_tx.sv
// -----------------------------------------------------------------------------
// trace_uart_tx
// Samples the integer parts of the core's Q16.16 outputs every DECIM enabled
// cycles into a small frame FIFO and sends each sample as an 8-byte frame
// (A5, I hi/lo, R hi/lo, P hi/lo, XOR checksum) over an 8N1 UART.
//   clk       - system clock
//   go        - asynchronous active-high reset (shared with the core)
//   I1/R1/Pt  - core outputs, Q16.16 unsigned; only [31:16] is kept
//   enable    - sampling enable, level-sensitive
//   txd       - UART serial output, idle high
//   busy      - high while a frame is being shifted out
//   overflow  - sticky, set when a sample is dropped on a full FIFO
//   frame_cnt - frames fully transmitted, wraps
// -----------------------------------------------------------------------------
module trace_uart_tx
    import trace_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DECIM        = 2048,
    parameter int DEPTH        = 16
) (
    input  logic        clk,
    input  logic        go,
    input  logic [31:0] I1,
    input  logic [31:0] R1,
    input  logic [31:0] Pt,
    input  logic        enable,
    output logic        txd,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            DW        = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(FRAME_BYTES - 1);

    // Decimation and capture
    logic [DW-1:0] dec_q, dec_d;
    logic          strobe_q, strobe_d;
    logic          overflow_q, overflow_d;

    // Frame FIFO; the extra pointer bit tells full from empty.
    sample_t       mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;
    sample_t       fifo_head, sample_word;

    // Frame sequencer
    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    sample_t       word_q, word_d;
    logic [7:0]    chk_q, chk_d;
    logic          busy_q, busy_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          byte_start, byte_ready;
    logic [7:0]    byte_data;

    // Fractional bits of the inputs are never transmitted.
    logic          unused_frac;
    assign unused_frac = ^{I1[15:0], R1[15:0], Pt[15:0]};

    assign sample_word = {I1[31:16], R1[31:16], Pt[31:16]};
    assign fifo_head   = mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // The strobe is registered, so the word is taken one edge after the wrap.
    always_comb begin
        dec_d      = dec_q;
        strobe_d   = 1'b0;
        if (enable) begin
            strobe_d = (dec_q == DEC_LAST);
            dec_d    = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
        end
        push       = strobe_q && (!fifo_full || pop);
        overflow_d = overflow_q | (strobe_q && !push);
    end

    // While a frame is on the line the sequencer waits in ST_DATA; the bit
    // level START/DATA/STOP phases live in the byte transmitter.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        chk_d       = chk_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;
        byte_start  = 1'b0;
        byte_data   = SYNC_BYTE;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop        = 1'b1;
                word_d     = fifo_head;
                chk_d      = frame_checksum(fifo_head);
                idx_d      = '0;
                busy_d     = 1'b1;
                byte_start = 1'b1;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                if (byte_ready) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d      = idx_q + 1'b1;
                        byte_start = 1'b1;
                        byte_data  = frame_byte(word_q, chk_q, idx_q + 1'b1);
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        busy_d      = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge go) begin
        if (go) begin
            dec_q       <= '0;
            strobe_q    <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            word_q      <= '0;
            chk_q       <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            dec_q       <= dec_d;
            strobe_q    <= strobe_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_q + (AW + 1)'(push);
            rd_ptr_q    <= rd_ptr_q + (AW + 1)'(pop);
            state_q     <= state_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            chk_q       <= chk_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers alone decide which
    // entries are valid, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= sample_word;
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (go),
        .start_i (byte_start),
        .data_i  (byte_data),
        .ready_o (byte_ready),
        .txd_o   (txd)
    );

    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_trace_uart_tx
// Directed bench for trace_uart_tx with CLKS_PER_BIT=4, DEPTH=4. The main
// instance uses DECIM=400; a second instance with DECIM=40 is driven past the
// FIFO capacity. Expected frames are written out by hand.
// -----------------------------------------------------------------------------
module tb_trace_uart_tx;

    logic        clk = 1'b0;
    logic        go;
    logic [31:0] I1, R1, Pt;
    logic        enable, enable2;
    logic        txd, busy, overflow;
    logic [15:0] frame_cnt;
    logic        txd2, busy2, overflow2;
    logic [15:0] frame_cnt2;

    logic        sel;
    logic        txd_mon, busy_mon;
    assign txd_mon  = sel ? txd2  : txd;
    assign busy_mon = sel ? busy2 : busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] FRAME_A = 64'hA5_00_0A_21_34_04_00_1B;
    localparam logic [63:0] FRAME_B = 64'hA5_12_34_AB_CD_00_FF_BF;

    always #5 clk = ~clk;

    trace_uart_tx #(.CLKS_PER_BIT(4), .DECIM(400), .DEPTH(4)) dut (
        .clk       (clk),
        .go        (go),
        .I1        (I1),
        .R1        (R1),
        .Pt        (Pt),
        .enable    (enable),
        .txd       (txd),
        .busy      (busy),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    trace_uart_tx #(.CLKS_PER_BIT(4), .DECIM(40), .DEPTH(4)) dut_ovf (
        .clk       (clk),
        .go        (go),
        .I1        (I1),
        .R1        (R1),
        .Pt        (Pt),
        .enable    (enable2),
        .txd       (txd2),
        .busy      (busy2),
        .overflow  (overflow2),
        .frame_cnt (frame_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits on falling edges for txd_mon low; n is the index of the posedge
    // just before the negedge where it was first seen low.
    task automatic find_low(input int limit, output int n, output bit found);
        n     = 0;
        found = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            if (txd_mon === 1'b0) begin
                found = 1'b1;
                break;
            end
            n++;
        end
    endtask

    // Called on the first low cycle of a start bit. Compares every cycle of
    // the 320-cycle frame to the ideal waveform and decodes mid-bit samples.
    task automatic frame_wave(input logic [63:0] exp, output int errs, output logic [63:0] got);
        errs = 0;
        got  = '0;
        for (int c = 0; c < 320; c++) begin
            int         b, p;
            logic [7:0] eb;
            logic       e;
            if (c > 0) @(negedge clk);
            b  = c / 40;
            p  = (c % 40) / 4;
            eb = exp[63 - 8*b -: 8];
            e  = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : eb[p-1];
            if (txd_mon !== e || busy_mon !== 1'b1) errs++;
            if ((c % 4) == 2 && p >= 1 && p <= 8) got[56 - 8*b + p - 1] = txd_mon;
        end
        @(negedge clk);
        if (busy_mon !== 1'b0) errs++;
    endtask

    initial begin
        int          n, errs, edges, frames;
        bit          found;
        logic [63:0] got;

        go = 1'b1; enable = 1'b0; enable2 = 1'b0; sel = 1'b0;
        I1 = 32'h000A_8000; R1 = 32'h2134_0000; Pt = 32'h0400_1234;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd",       txd,       1);
        check("rst_busy",      busy,      0);
        check("rst_overflow",  overflow,  0);
        check("rst_frame_cnt", frame_cnt, 0);
        go = 1'b0;
        edges = 0;
        repeat (1000) begin
            @(negedge clk);
            if (txd !== 1'b1) edges++;
        end
        check("idle_quiet", edges, 0);

        // Single frame and bit timing
        enable = 1'b1;
        find_low(1000, n, found);
        check("first_found", found, 1);
        check("start_latency", n, 402);
        if (found) begin
            frame_wave(FRAME_A, errs, got);
            check("frame_a_wave",  errs, 0);
            check("frame_a_bytes", got,  FRAME_A);
            check("frame_a_cnt",   frame_cnt, 1);
        end

        // Reset during data of byte 3 (bit 1 of 0x21 is 0 on the line)
        find_low(200, n, found);
        check("second_found", found, 1);
        repeat (130) @(negedge clk);
        check("pre_reset_txd", txd, 0);
        #2 go = 1'b1;
        #1;
        check("async_txd",       txd,       1);
        check("async_busy",      busy,      0);
        check("async_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        go = 1'b0;
        I1 = 32'h1234_FFFF; R1 = 32'hABCD_0001; Pt = 32'h00FF_8000;
        find_low(1000, n, found);
        check("resync_latency", n, 402);
        if (found) begin
            frame_wave(FRAME_B, errs, got);
            check("frame_b_wave",  errs, 0);
            check("frame_b_bytes", got,  FRAME_B);
            check("frame_b_cnt",   frame_cnt, 1);
        end

        // frame_cnt wrap
        enable = 1'b0;
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        check("forced_cnt", frame_cnt, 16'hFFFF);
        enable = 1'b1;
        find_low(200, n, found);
        check("wrap_found", found, 1);
        if (found) begin
            frame_wave(FRAME_B, errs, got);
            check("wrap_wave", errs, 0);
            check("wrap_cnt",  frame_cnt, 0);
        end
        enable = 1'b0;

        // Overflow on the DECIM=40 instance: pushes land at cycles 40..200,
        // 400 and 720; everything else finds the FIFO full.
        sel     = 1'b1;
        enable2 = 1'b1;
        frames  = 0;
        fork
            begin
                repeat (800) @(negedge clk);
                enable2 = 1'b0;
            end
            begin
                do begin
                    find_low(400, n, found);
                    if (found) begin
                        frame_wave(FRAME_B, errs, got);
                        check("ovf_wave", errs, 0);
                        check("ovf_checksum",
                              got[55:48] ^ got[47:40] ^ got[39:32] ^ got[31:24] ^
                              got[23:16] ^ got[15:8]  ^ got[7:0], 0);
                        frames++;
                    end
                end while (found && frames < 20);
            end
        join
        check("ovf_flag",   overflow2,  1);
        check("ovf_frames", frames,     7);
        check("ovf_cnt",    frame_cnt2, frames);
        check("main_no_ovf", overflow,  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_uart_tx.md
# trace_uart_tx

Trace readout for the plasma-dynamics core. The block samples the core's Q16.16 outputs `I1`, `R1` and `Pt` at a fixed decimation rate and keeps their integer parts in a small frame FIFO. It sends each sample to the host as a framed, checksummed byte stream over an 8N1 UART line. It sits beside the simulation core in the top level and is the consumer/host-facing end of the core's output interface.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; 100 MHz / 115200.
- `DECIM`, 2048: clock cycles between samples; one simulated time unit at the core's t resolution.
- `DEPTH`, 16: FIFO depth in frames; must be a power of two, ≥2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `go`  in  1  asynchronous, active-high reset (same `go` that restarts the core).
- `I1`  in  32  core output I, Q16.16 unsigned.
- `R1`  in  32  core output R, Q16.16 unsigned.
- `Pt`  in  32  core output P(t), Q16.16 unsigned.
- `enable`  in  1  sampling enable; level-sensitive.
- `txd`  out  1  UART serial output; idle high.
- `busy`  out  1  high while a frame is being shifted out.
- `overflow`  out  1  sticky; set when a sample is dropped because the FIFO is full.
- `frame_cnt`  out  16  count of frames fully transmitted; wraps 0xFFFF→0.

## Operation
**Reset values** (while `go` is high): `txd`=1, `busy`=0, `overflow`=0, `frame_cnt`=0, FIFO empty, decimation counter 0, FSM in IDLE.

**Sampling**
- The decimation counter runs 0..DECIM-1 only while `enable`=1 and holds otherwise.
- At count DECIM-1 it wraps to 0 and raises a one-cycle capture strobe.
- On the strobe, the FIFO word is `{I1[31:16], R1[31:16], Pt[31:16]}` (48 bits), taken from that cycle's input values.
- The word is written if the FIFO is not full, or if a pop happens in the same cycle. Otherwise it is dropped and `overflow` is set.
- `overflow` clears only on reset.

**Frame format** (8 bytes, in order)
- 0xA5 (sync)
- I hi, I lo, R hi, R lo, P hi, P lo
- checksum = XOR of the six data bytes

**Byte format:** 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1.

**FSM**
- IDLE: if the FIFO is not empty, go to LOAD.
- LOAD: pop the FIFO, latch the 48-bit word, compute the checksum, set byte index 0, raise `busy`, go to START.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive bit k for CLKS_PER_BIT cycles, k = 0..7, then go to STOP.
- STOP: drive 1 for CLKS_PER_BIT cycles. Then:
  - if byte index < 7: increment it and go to START;
  - else: increment `frame_cnt`, drop `busy`, go to IDLE.
- Frames are sent back-to-back with no idle bit time between bytes. At least one idle cycle separates frames (IDLE→LOAD).

**Boundary conditions**
- `enable` falling mid-frame: the in-flight frame and queued frames still complete; only sampling stops.
- `go` asserted mid-frame: `txd` goes high immediately (asynchronous), and the partial frame is lost. The host resynchronises on 0xA5 plus the checksum.
- Inputs are sampled only on the strobe; their values between strobes are irrelevant.

## Timing
- Capture strobe at edge n: FIFO write at edge n+1. If the FSM is idle, LOAD at n+2 and `txd` falls (start bit) at n+3.
- One byte = 10·CLKS_PER_BIT cycles.
- One frame = 80·CLKS_PER_BIT cycles. IDLE→LOAD adds 1 cycle and LOAD adds 1 cycle, so frame-to-frame pitch is 80·CLKS_PER_BIT + 2.
- Sustained throughput requires DECIM ≥ 80·CLKS_PER_BIT + 2. Otherwise `overflow` eventually sets; this is allowed, not an error.
- `frame_cnt` increments on the edge that ends the last stop bit; `busy` falls on the same edge.

## Structure
- Shared package:
  - SYNC_BYTE = 8'hA5
  - FRAME_BYTES = 8
  - FSM state enum {IDLE, LOAD, START, DATA, STOP}
  - 48-bit sample word typedef
- Natural sub-module: `uart_byte_tx`, holding the bit-timer, bit counter and shift register. It has a start/ready handshake and sends one byte on `txd`. The parent FSM then reduces to byte sequencing plus the FIFO.
- The FIFO is inline: register array plus pointers, with one extra pointer bit for full/empty.

## Test plan
Benches use CLKS_PER_BIT=4, DECIM=400, DEPTH=4.

1. Reset: hold `go` 3 cycles → `txd`=1, `busy`=0, `overflow`=0, `frame_cnt`=0; no `txd` edges for 1000 cycles with `enable`=0.
2. Single frame: `enable`=1 with I1=0x000A_8000, R1=0x2134_0000, Pt=0x0400_1234 → UART monitor decodes A5 00 0A 21 34 04 00 1B (checksum 0x1B); `frame_cnt`=1.
3. Bit timing: in scenario 2, every bit lasts exactly 4 cycles; the start bit falls exactly 3 cycles after the first capture strobe.
4. Overflow: DECIM=40, run 20 strobes → `overflow`=1. Every frame decoded still carries a valid checksum, and `frame_cnt` equals the number of frames decoded.
5. Reset mid-frame: assert `go` during DATA of byte 3 → `txd`=1 within the same cycle and all counters are 0. After release, the next frame is complete and valid.
6. `frame_cnt` wrap: force the count to 0xFFFF, send one frame → `frame_cnt`=0.
